// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - GF(2^5) symbol types and arithmetic helpers shared by the RS(31,k) decoder stages
package rs_pkg;

  localparam int SYM_W = 5;
  localparam int N     = 31;

  typedef logic [SYM_W-1:0] sym_t;
  typedef logic [4:0]       cnt_t;

  // Low bits of x^5+x^2+1; the x^5 term is implied by the shifted-out MSB.
  localparam sym_t GF_POLY  = 5'h05;
  localparam sym_t GF_ALPHA = 5'h02;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  function automatic sym_t gf_mul(sym_t a, sym_t b);
    sym_t p;
    sym_t t;
    p = '0;
    t = a;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) p = p ^ t;
      t = t[SYM_W-1] ? ((t << 1) ^ GF_POLY) : (t << 1);
    end
    return p;
  endfunction

  // Exponent is reduced mod N so negative powers give the field inverse.
  function automatic sym_t gf_alpha_pow(int e);
    sym_t r;
    int   m;
    r = 5'h01;
    m = ((e % N) + N) % N;
    for (int i = 0; i < N; i++) begin
      if (i < m) r = gf_mul(r, GF_ALPHA);
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_gf_cmul.sv
// rtl/rs_gf_cmul.sv - constant multiplier y = x * alpha^EXP in GF(2^5)
// The constant folds at elaboration, leaving a pure XOR network.
module rs_gf_cmul
  import rs_pkg::*;
#(
  parameter int EXP = 1
) (
  input  logic [SYM_W-1:0] x_i,
  output logic [SYM_W-1:0] y_o
);

  localparam sym_t K = gf_alpha_pow(EXP);

  assign y_o = gf_mul(x_i, K);

endmodule

// File: rtl/rs_syndrome_gen.sv
// rtl/rs_syndrome_gen.sv - RS(31,k) syndrome generator with parallel Horner accumulators
// Symbols arrive highest-degree first; syndromes leave on a valid/ready register slice.
module rs_syndrome_gen
  import rs_pkg::*;
#(
  parameter int NSYN = 4,
  parameter int FCR  = 1
) (
  input  logic                  clock2,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic [SYM_W-1:0]      in_sym,
  output logic                  in_ready,
  output logic                  syn_valid,
  input  logic                  syn_ready,
  output logic [NSYN*SYM_W-1:0] syn_out,
  output logic                  syn_zero,
  output logic                  err
);

  localparam cnt_t LAST_CNT = cnt_t'(N - 1);

  typedef logic [NSYN-1:0][SYM_W-1:0] syn_vec_t;

  state_t   state_q, state_d;
  cnt_t     cnt_q, cnt_d;
  syn_vec_t acc_q, acc_d;
  syn_vec_t syn_q, syn_d;
  syn_vec_t scaled, horner;
  logic     syn_valid_q, syn_valid_d;
  logic     syn_zero_q, syn_zero_d;
  logic     err_q, err_d;
  logic     accept, complete, frame_err, at_last, out_busy;

  for (genvar j = 0; j < NSYN; j++) begin : g_horner
    rs_gf_cmul #(.EXP(FCR + j)) u_cmul (
      .x_i (acc_q[j]),
      .y_o (scaled[j])
    );
    assign horner[j] = scaled[j] ^ in_sym;
  end

  // Only the completing symbol needs the output register, so only it is stalled.
  assign at_last  = (state_q == ACCUM) && (cnt_q == LAST_CNT);
  assign out_busy = syn_valid_q && !syn_ready;
  assign in_ready = !reset && !(out_busy && at_last);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clock2) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      syn_q       <= '0;
      syn_valid_q <= 1'b0;
      syn_zero_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      syn_q       <= syn_d;
      syn_valid_q <= syn_valid_d;
      syn_zero_q  <= syn_zero_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    complete  = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_sop) begin
            acc_d   = {NSYN{in_sym}};
            cnt_d   = 5'd1;
            state_d = ACCUM;
          end else begin
            frame_err = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          if (in_sop) begin
            // Premature SOP: drop the partial word and restart on this symbol.
            frame_err = 1'b1;
            acc_d     = {NSYN{in_sym}};
            cnt_d     = 5'd1;
          end else begin
            acc_d = horner;
            cnt_d = cnt_q + 5'd1;
            if (at_last) begin
              complete = 1'b1;
              cnt_d    = '0;
              state_d  = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    syn_d       = syn_q;
    syn_valid_d = syn_valid_q;
    syn_zero_d  = syn_zero_q;
    err_d       = frame_err;
    if (complete) begin
      syn_d       = horner;
      syn_valid_d = 1'b1;
      syn_zero_d  = (horner == '0);
    end else if (syn_valid_q && syn_ready) begin
      syn_valid_d = 1'b0;
    end
  end

  assign syn_out   = syn_q;
  assign syn_valid = syn_valid_q;
  assign syn_zero  = syn_zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rs_syndrome_gen.sv
// tb/tb_rs_syndrome_gen.sv - directed self-checking bench for rs_syndrome_gen
module tb_rs_syndrome_gen;
  import rs_pkg::*;

  localparam int NSYN = 4;

  // g(x) = (x+a)(x+a^2)(x+a^3)(x+a^4) = x^4 + 1E x^3 + 06 x^2 + 09 x + 11
  localparam logic [19:0] SYN_ZERO_V = 20'h0;
  localparam logic [19:0] SYN_POS0   = {5'h01, 5'h01, 5'h01, 5'h01};
  localparam logic [19:0] SYN_POS1   = {5'h10, 5'h08, 5'h04, 5'h02};
  localparam logic [19:0] SYN_POS30  = {5'h0B, 5'h16, 5'h09, 5'h12};

  logic                  clock2 = 1'b0;
  logic                  reset = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_sop = 1'b0;
  sym_t                  in_sym = '0;
  logic                  syn_ready = 1'b0;
  logic                  in_ready, syn_valid, syn_zero, err;
  logic [NSYN*SYM_W-1:0] syn_out;

  sym_t word [N];
  int   compared = 0;
  int   mismatched = 0;

  always #5 clock2 = ~clock2;

  rs_syndrome_gen #(.NSYN(NSYN), .FCR(1)) dut (
    .clock2    (clock2),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .in_sym    (in_sym),
    .in_ready  (in_ready),
    .syn_valid (syn_valid),
    .syn_ready (syn_ready),
    .syn_out   (syn_out),
    .syn_zero  (syn_zero),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_word();
    for (int i = 0; i < N; i++) word[i] = '0;
  endtask

  task automatic set_g(input int first);
    word[first]     = 5'h01;
    word[first + 1] = 5'h1E;
    word[first + 2] = 5'h06;
    word[first + 3] = 5'h09;
    word[first + 4] = 5'h11;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clock2);
    while (!in_ready && n < 100) begin
      @(negedge clock2);
      n++;
    end
    if (n == 100) check("in_ready_timeout", in_ready, 1);
  endtask

  // Sends word[first..last]; returns #1 after the edge that accepted the last one.
  task automatic send_syms(input int first, input int last, input bit gaps);
    for (int i = first; i <= last; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clock2);
          #1;
        end
      end
      in_valid = 1'b1;
      in_sop   = (i == 0);
      in_sym   = word[i];
      wait_ready();
      @(posedge clock2);
      #1;
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_sym   = '0;
    end
  endtask

  task automatic consume();
    syn_ready = 1'b1;
    @(posedge clock2);
    #1;
    syn_ready = 1'b0;
    check("syn_valid_drop", syn_valid, 0);
  endtask

  task automatic stray_symbol(input string tag);
    in_valid = 1'b1;
    in_sop   = 1'b0;
    in_sym   = 5'h1F;
    @(posedge clock2);
    #1;
    in_valid = 1'b0;
    in_sym   = '0;
    check(tag, err, 1);
    @(posedge clock2);
    #1;
    check({tag, "_clear"}, err, 0);
  endtask

  initial begin
    #1;
    check("rst_in_ready", in_ready, 0);
    repeat (3) @(posedge clock2);
    #1;
    check("rst_syn_valid", syn_valid, 0);
    check("rst_syn_out", syn_out, 0);
    check("rst_syn_zero", syn_zero, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    @(negedge clock2);
    check("idle_in_ready", in_ready, 1);
    @(posedge clock2);
    #1;

    // All-zero codeword, and no early syn_valid at symbol 30
    clear_word();
    send_syms(0, 29, 0);
    check("zero_early_valid", syn_valid, 0);
    send_syms(30, 30, 0);
    check("zero_valid", syn_valid, 1);
    check("zero_out", syn_out, SYN_ZERO_V);
    check("zero_flag", syn_zero, 1);
    check("zero_err", err, 0);
    consume();

    // Single error at position 0, held while stalled
    clear_word();
    word[30] = 5'h01;
    send_syms(0, 30, 1);
    check("pos0_valid", syn_valid, 1);
    check("pos0_out", syn_out, SYN_POS0);
    check("pos0_flag", syn_zero, 0);
    repeat (3) begin
      @(posedge clock2);
      #1;
    end
    check("pos0_hold_valid", syn_valid, 1);
    check("pos0_hold_out", syn_out, SYN_POS0);
    consume();

    // Single error at position 30
    clear_word();
    word[0] = 5'h01;
    send_syms(0, 30, 1);
    check("pos30_out", syn_out, SYN_POS30);
    check("pos30_flag", syn_zero, 0);
    consume();

    // Codewords: g(x), x^26 g(x) and their sum
    clear_word();
    set_g(26);
    send_syms(0, 30, 1);
    check("cw_low_out", syn_out, SYN_ZERO_V);
    check("cw_low_flag", syn_zero, 1);
    consume();
    clear_word();
    set_g(0);
    set_g(26);
    send_syms(0, 30, 1);
    check("cw_sum_out", syn_out, SYN_ZERO_V);
    check("cw_sum_flag", syn_zero, 1);
    consume();

    // Back-to-back: next word accumulates while position-1 syndromes are pending
    clear_word();
    word[29] = 5'h01;
    send_syms(0, 30, 1);
    check("pos1_out", syn_out, SYN_POS1);
    clear_word();
    set_g(0);
    send_syms(0, 29, 1);
    check("b2b_pending_valid", syn_valid, 1);
    check("b2b_pending_out", syn_out, SYN_POS1);
    in_valid = 1'b1;
    in_sym   = word[30];
    @(negedge clock2);
    check("b2b_stall_ready", in_ready, 0);
    @(posedge clock2);
    #1;
    @(negedge clock2);
    check("b2b_stall_ready2", in_ready, 0);
    check("b2b_stall_out", syn_out, SYN_POS1);
    syn_ready = 1'b1;
    #1;
    check("b2b_release_ready", in_ready, 1);
    @(posedge clock2);
    #1;
    in_valid  = 1'b0;
    syn_ready = 1'b0;
    check("b2b_new_valid", syn_valid, 1);
    check("b2b_new_out", syn_out, SYN_ZERO_V);
    check("b2b_new_flag", syn_zero, 1);
    consume();

    // Framing: stray symbol in IDLE, then a second SOP after 10 symbols
    stray_symbol("idle_stray_err");
    check("idle_stray_valid", syn_valid, 0);
    for (int i = 0; i < N; i++) word[i] = sym_t'(i * 7 + 3);
    send_syms(0, 9, 0);
    check("junk_err", err, 0);
    clear_word();
    word[30] = 5'h01;
    send_syms(0, 0, 0);
    check("resop_err", err, 1);
    send_syms(1, 30, 1);
    check("resop_valid", syn_valid, 1);
    check("resop_out", syn_out, SYN_POS0);
    check("resop_err_done", err, 0);
    consume();

    // Reset mid-word
    clear_word();
    word[0] = 5'h01;
    send_syms(0, 14, 0);
    reset = 1'b1;
    @(posedge clock2);
    #1;
    reset = 1'b0;
    check("midrst_valid", syn_valid, 0);
    check("midrst_out", syn_out, 0);
    stray_symbol("midrst_idle_err");
    send_syms(0, 30, 1);
    check("midrst_word_out", syn_out, SYN_POS30);

    // Reset while syndromes are pending
    reset = 1'b1;
    #1;
    check("pendrst_in_ready", in_ready, 0);
    @(posedge clock2);
    #1;
    reset = 1'b0;
    check("pendrst_valid", syn_valid, 0);
    check("pendrst_out", syn_out, 0);
    check("pendrst_flag", syn_zero, 0);
    clear_word();
    set_g(26);
    send_syms(0, 30, 1);
    check("pendrst_word_valid", syn_valid, 1);
    check("pendrst_word_flag", syn_zero, 1);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

endmodule
